// File: rtl/sync_debounce_bank.sv
// ---------------------------------------------------------------------------
// sync_debounce_bank
//
// Multi-channel clock-domain-crossing synchroniser with a per-channel
// debounce filter and registered edge detection. Each asynchronous input bit
// passes through a DEPTH-stage flop chain. A new synchronised value is
// accepted onto dout only after it has held for STABLE_COUNT consecutive
// cycles. Intended to sit between board-level async inputs (triggers,
// buttons, status lines) and control FSMs or register banks.
//
// Parameters
//   CHANNELS      number of independent 1-bit channels (min 1)
//   DEPTH         synchroniser stages; values below 2 are raised to 2
//   STABLE_COUNT  cycles a new value must hold; values below 1 are raised to 1
//   INIT          reset value of the sync chain, raw_sync and dout
//
// Ports
//   clk          in   1         system clock
//   aresetn      in   1         asynchronous active-low reset
//   din          in   CHANNELS  asynchronous inputs
//   raw_sync     out  CHANNELS  last sync-chain stage, unfiltered
//   dout         out  CHANNELS  debounced, synchronised value (registered)
//   stable       out  CHANNELS  1 when raw_sync == dout (no change pending)
//   rise         out  CHANNELS  1-cycle pulse on dout 0->1 (registered)
//   fall         out  CHANNELS  1-cycle pulse on dout 1->0 (registered)
//   evt_clr      in   CHANNELS  per-channel clear of evt_pending   (optional)
//   evt_pending  out  CHANNELS  sticky per-channel event flags     (optional)
//   irq          out  1         registered OR of evt_pending       (optional)
//
// Optional feature: define the macro SYNC_DEBOUNCE_IRQ_EN to add the sticky
// event flags and interrupt output. Without it those ports do not exist.
// ---------------------------------------------------------------------------
module sync_debounce_bank #(
    parameter int                  CHANNELS     = 4,
    parameter int                  DEPTH        = 2,
    parameter int                  STABLE_COUNT = 4,
    parameter logic [CHANNELS-1:0] INIT         = '0
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] raw_sync,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] stable,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
`ifdef SYNC_DEBOUNCE_IRQ_EN
    ,
    input  logic [CHANNELS-1:0] evt_clr,
    output logic [CHANNELS-1:0] evt_pending,
    output logic                irq
`endif
);

    // Out-of-range parameters are clamped rather than rejected so that
    // legacy instantiations with DEPTH=1 or STABLE_COUNT=0 still build.
    localparam int DEPTH_EFF  = (DEPTH < 2) ? 2 : DEPTH;
    localparam int STABLE_EFF = (STABLE_COUNT < 1) ? 1 : STABLE_COUNT;
    localparam int CNT_W      = (STABLE_EFF <= 2) ? 1 : $clog2(STABLE_EFF);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_EFF - 1);

    logic [CHANNELS-1:0]            syncStage_q [DEPTH_EFF];
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q;
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_d;
    logic [CHANNELS-1:0]            dout_q;
    logic [CHANNELS-1:0]            dout_d;
    logic [CHANNELS-1:0]            rise_q;
    logic [CHANNELS-1:0]            rise_d;
    logic [CHANNELS-1:0]            fall_q;
    logic [CHANNELS-1:0]            fall_d;

    // Plain flop chain; only stage 0 can go metastable, later stages give it
    // time to resolve before anything downstream looks at the value.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < DEPTH_EFF; k++) begin
                syncStage_q[k] <= INIT;
            end
        end else begin
            syncStage_q[0] <= din;
            for (int k = 1; k < DEPTH_EFF; k++) begin
                syncStage_q[k] <= syncStage_q[k-1];
            end
        end
    end

    assign raw_sync = syncStage_q[DEPTH_EFF-1];

    // The counter only ever counts while raw_sync disagrees with dout and is
    // cleared at CNT_MAX when dout takes the new value, so it cannot wrap.
    // Any return to agreement (a glitch) drops it straight back to zero.
    always_comb begin
        dout_d = dout_q;
        rise_d = '0;
        fall_d = '0;
        cnt_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (raw_sync[i] != dout_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    dout_d[i] = raw_sync[i];
                    rise_d[i] = raw_sync[i];
                    fall_d[i] = ~raw_sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounced value and edge pulses are registered together, so a pulse
    // is high in exactly the cycle where dout shows its new value.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q  <= '0;
            dout_q <= INIT;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout   = dout_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign stable = ~(raw_sync ^ dout_q);

`ifdef SYNC_DEBOUNCE_IRQ_EN
    logic [CHANNELS-1:0] evtPending_q;
    logic [CHANNELS-1:0] evtPending_d;
    logic                irq_q;

    // A new edge must never be lost to a software clear racing it, so the
    // set term is OR-ed in after the clear has been applied.
    assign evtPending_d = (evtPending_q & ~evt_clr) | rise_q | fall_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            evtPending_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            evtPending_q <= evtPending_d;
            irq_q        <= |evtPending_q;
        end
    end

    assign evt_pending = evtPending_q;
    assign irq         = irq_q;
`endif

endmodule

// File: tb/tb_sync_debounce_bank.sv
// ---------------------------------------------------------------------------
// tb_sync_debounce_bank
//
// Self-checking bench for sync_debounce_bank. A cycle model predicts every
// output for each clock; predictions go into a scoreboard queue when the
// stimulus is driven and are popped and compared after the clock edge.
// Directed checks with hand-derived constants cover latency, glitch
// rejection, simultaneous edges, async reset and the optional IRQ logic.
// A second, tiny instance covers the DEPTH=3 / STABLE_COUNT=1 build.
// ---------------------------------------------------------------------------
module tb_sync_debounce_bank;

    localparam int TB_DEPTH  = 2;
    localparam int TB_STABLE = 4;

    logic       clk;
    logic       aresetn;
    logic [3:0] din;
    logic [3:0] raw_sync;
    logic [3:0] dout;
    logic [3:0] stable;
    logic [3:0] rise;
    logic [3:0] fall;

    logic [0:0] din2;
    logic [0:0] raw2;
    logic [0:0] dout2;
    logic [0:0] stable2;
    logic [0:0] rise2;
    logic [0:0] fall2;

`ifdef SYNC_DEBOUNCE_IRQ_EN
    logic [3:0] evtClr;
    logic [3:0] evtPending;
    logic       irq;
    logic [0:0] evtPending2;
    logic       irq2;
`endif

    int checkCount = 0;
    int failCount  = 0;

    sync_debounce_bank #(
        .CHANNELS(4), .DEPTH(TB_DEPTH), .STABLE_COUNT(TB_STABLE), .INIT(4'h0)
    ) dut (
        .clk(clk), .aresetn(aresetn), .din(din), .raw_sync(raw_sync),
        .dout(dout), .stable(stable), .rise(rise), .fall(fall)
`ifdef SYNC_DEBOUNCE_IRQ_EN
        , .evt_clr(evtClr), .evt_pending(evtPending), .irq(irq)
`endif
    );

    sync_debounce_bank #(
        .CHANNELS(1), .DEPTH(3), .STABLE_COUNT(1), .INIT(1'b0)
    ) dut2 (
        .clk(clk), .aresetn(aresetn), .din(din2), .raw_sync(raw2),
        .dout(dout2), .stable(stable2), .rise(rise2), .fall(fall2)
`ifdef SYNC_DEBOUNCE_IRQ_EN
        , .evt_clr(1'b0), .evt_pending(evtPending2), .irq(irq2)
`endif
    );

    // 10 ns clock; inputs change on the falling edge, outputs sampled 1 ns
    // after the rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case something stalls the stimulus sequence.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [3:0] raw;
        logic [3:0] dout;
        logic [3:0] stable;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] pend;
        logic       irq;
    } expT;

    expT sbQueue[$];

    // Reference model state
    logic [3:0] mStage [TB_DEPTH];
    logic [3:0] mDout;
    logic [3:0] mRise;
    logic [3:0] mFall;
    logic [3:0] mPend;
    logic       mIrq;
    int         mRun [4];

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Model reset: everything back to the INIT / idle state.
    task automatic modelReset();
        for (int k = 0; k < TB_DEPTH; k++) mStage[k] = 4'h0;
        mDout = 4'h0;
        mRise = 4'h0;
        mFall = 4'h0;
        mPend = 4'h0;
        mIrq  = 1'b0;
        for (int c = 0; c < 4; c++) mRun[c] = 0;
    endtask

    // Model one rising edge: mRun counts how long raw has disagreed with
    // dout; the new value is taken on the STABLE-th disagreeing edge.
    task automatic modelEdge(input logic [3:0] d, input logic [3:0] clr);
        logic [3:0] raw;
        logic [3:0] nRise;
        logic [3:0] nFall;
        logic [3:0] nPend;
        logic       nIrq;
        raw   = mStage[TB_DEPTH-1];
        nPend = (mPend & ~clr) | mRise | mFall;
        nIrq  = |mPend;
        nRise = 4'h0;
        nFall = 4'h0;
        for (int c = 0; c < 4; c++) begin
            if (raw[c] != mDout[c]) begin
                mRun[c]++;
                if (mRun[c] == TB_STABLE) begin
                    mDout[c] = raw[c];
                    mRun[c]  = 0;
                    if (raw[c]) nRise[c] = 1'b1;
                    else        nFall[c] = 1'b1;
                end
            end else begin
                mRun[c] = 0;
            end
        end
        for (int k = TB_DEPTH - 1; k > 0; k--) mStage[k] = mStage[k-1];
        mStage[0] = d;
        mRise = nRise;
        mFall = nFall;
        mPend = nPend;
        mIrq  = nIrq;
    endtask

    // Drive one clock worth of stimulus, push the prediction, then pop it
    // and compare against the DUT after the edge.
    task automatic applyStimulus(input logic rstn, input logic [3:0] d,
                                 input logic [3:0] clr);
        expT e;
        expT got;
        @(negedge clk);
        aresetn = rstn;
        din     = d;
`ifdef SYNC_DEBOUNCE_IRQ_EN
        evtClr  = clr;
`endif
        if (!rstn) modelReset();
        else       modelEdge(d, clr);
        e.raw    = mStage[TB_DEPTH-1];
        e.dout   = mDout;
        e.stable = ~(mStage[TB_DEPTH-1] ^ mDout);
        e.rise   = mRise;
        e.fall   = mFall;
        e.pend   = mPend;
        e.irq    = mIrq;
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        got = sbQueue.pop_front();
        checkOutput("raw_sync", raw_sync, got.raw);
        checkOutput("dout",     dout,     got.dout);
        checkOutput("stable",   stable,   got.stable);
        checkOutput("rise",     rise,     got.rise);
        checkOutput("fall",     fall,     got.fall);
`ifdef SYNC_DEBOUNCE_IRQ_EN
        checkOutput("evt_pending", evtPending, got.pend);
        checkOutput("irq",         irq,        got.irq);
`endif
    endtask

    // Main stimulus sequence
    initial begin
        int firstIdx;
        int rawIdx;
        int pulseCnt;
        logic [3:0] edgeVec;
        logic sawEdge1;
        logic [3:0] hold;

        aresetn = 1'b0;
        din     = 4'hF;
        din2    = 1'b0;
`ifdef SYNC_DEBOUNCE_IRQ_EN
        evtClr  = 4'h0;
`endif
        modelReset();

        // Reset held with all inputs high: nothing may leak through.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'hF, 4'h0);
        checkOutput("reset_dout",   dout,   4'h0);
        checkOutput("reset_stable", stable, 4'hF);

        // Clean step on channel 0 right after release: DEPTH+STABLE = 6.
        firstIdx = 0; rawIdx = 0; pulseCnt = 0;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 4'h1, 4'h0);
            if (raw_sync[0] && rawIdx == 0) rawIdx = i;
            if (dout[0] && firstIdx == 0) firstIdx = i;
            if (rise[0]) pulseCnt++;
        end
        checkOutput("step_raw_latency",  rawIdx,   2);
        checkOutput("step_dout_latency", firstIdx, 6);
        checkOutput("step_rise_pulses",  pulseCnt, 1);

        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'h0, 4'h0);

        // Three-cycle glitch on channel 1 must be filtered out completely.
        sawEdge1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'h2, 4'h0);
            if (rise[1] || fall[1] || dout[1]) sawEdge1 = 1'b1;
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 4'h0, 4'h0);
            if (rise[1] || fall[1] || dout[1]) sawEdge1 = 1'b1;
        end
        checkOutput("glitch_no_edge", sawEdge1,  1'b0);
        checkOutput("glitch_stable",  stable[1], 1'b1);

        // Simultaneous rise on channels 1 and 3, then simultaneous fall.
        edgeVec = 4'h0; pulseCnt = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 4'hA, 4'h0);
            if (rise != 4'h0) begin edgeVec = rise; pulseCnt++; end
        end
        checkOutput("multi_rise_vec",    edgeVec,  4'hA);
        checkOutput("multi_rise_cycles", pulseCnt, 1);
        edgeVec = 4'h0; pulseCnt = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 4'h0, 4'h0);
            if (fall != 4'h0) begin edgeVec = fall; pulseCnt++; end
        end
        checkOutput("multi_fall_vec",    edgeVec,  4'hA);
        checkOutput("multi_fall_cycles", pulseCnt, 1);

        // Async reset mid-count on channel 2 (counter at 2 after 4 edges).
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'h4, 4'h0);
        #2;
        aresetn = 1'b0;
        #1;
        checkOutput("async_rst_dout",   dout,     4'h0);
        checkOutput("async_rst_raw",    raw_sync, 4'h0);
        checkOutput("async_rst_rise",   rise,     4'h0);
        checkOutput("async_rst_fall",   fall,     4'h0);
        checkOutput("async_rst_stable", stable,   4'hF);
        modelReset();
        firstIdx = 0;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 4'h4, 4'h0);
            if (dout[2] && firstIdx == 0) firstIdx = i;
        end
        checkOutput("post_rst_latency", firstIdx, 6);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'h0, 4'h0);

`ifdef SYNC_DEBOUNCE_IRQ_EN
        // Clear leftover flags, then walk the sticky-flag and irq timing.
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 4'h0, 4'hF);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 4'h0, 4'h0);
        checkOutput("irq_idle", irq, 1'b0);
        firstIdx = 0;
        for (int i = 1; i <= 10 && firstIdx == 0; i++) begin
            applyStimulus(1'b1, 4'h8, 4'h0);
            if (rise[3]) firstIdx = i;
        end
        checkOutput("irq_rise_seen", firstIdx != 0, 1'b1);
        applyStimulus(1'b1, 4'h8, 4'h0);
        checkOutput("pend_set", evtPending[3], 1'b1);
        checkOutput("irq_lag0", irq,           1'b0);
        applyStimulus(1'b1, 4'h8, 4'h0);
        checkOutput("irq_set",  irq,           1'b1);
        firstIdx = 0;
        for (int i = 1; i <= 10 && firstIdx == 0; i++) begin
            applyStimulus(1'b1, 4'h0, 4'h0);
            if (fall[3]) firstIdx = i;
        end
        checkOutput("irq_fall_seen", firstIdx != 0, 1'b1);
        applyStimulus(1'b1, 4'h0, 4'h8);
        checkOutput("pend_set_wins", evtPending[3], 1'b1);
        applyStimulus(1'b1, 4'h0, 4'h8);
        checkOutput("pend_cleared",  evtPending[3], 1'b0);
        checkOutput("irq_still_hi",  irq,           1'b1);
        applyStimulus(1'b1, 4'h0, 4'h0);
        checkOutput("irq_cleared",   irq,           1'b0);
`endif

        // Channel 0 toggling every cycle: dout must never move.
        sawEdge1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, (i % 2 == 0) ? 4'h1 : 4'h0, 4'h0);
            if (dout[0] || rise[0]) sawEdge1 = 1'b1;
        end
        checkOutput("toggle_no_update", sawEdge1, 1'b0);

        // Random hold lengths around the debounce threshold.
        for (int s = 0; s < 40; s++) begin
            hold = 4'($urandom_range(15, 0));
            for (int i = 0; i < int'($urandom_range(7, 1)); i++) begin
                applyStimulus(1'b1, hold, 4'($urandom_range(15, 0)));
            end
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 4'h0, 4'h0);

        // DEPTH=3, STABLE_COUNT=1 instance: dout follows after edge 4.
        firstIdx = 0; pulseCnt = 0;
        din2 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 4'h0, 4'h0);
            if (dout2[0] && firstIdx == 0) firstIdx = i;
            if (rise2[0]) pulseCnt++;
        end
        checkOutput("d3s1_latency", firstIdx, 4);
        checkOutput("d3s1_pulses",  pulseCnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
